// File: rtl/ddr3_dqs_delay_tracker.sv
// Read DQS delay tracker: majority-votes IOD eye-monitor flags and issues single-tap moves.
// Define DDR3_DQS_TRACK_HYST_EN to require two consecutive same-direction decisions per move.
module ddr3_dqs_delay_tracker #(
  parameter int SAMPLE_WIN = 16,
  parameter int THRESH     = 4,
  parameter int SETTLE_CYC = 8,
  parameter int TAP_INIT   = 1,
  parameter int TAP_MAX    = 127
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       TRACK_EN,
  input  logic       LOAD_REQ,
  input  logic       RD_VALID,
  input  logic       EYE_MONITOR_EARLY_0,
  input  logic       EYE_MONITOR_LATE_0,
  input  logic       DELAY_LINE_OUT_OF_RANGE_0,
  output logic       DELAY_LINE_MOVE_0,
  output logic       DELAY_LINE_DIRECTION_0,
  output logic       DELAY_LINE_LOAD_0,
  output logic       EYE_MONITOR_CLEAR_FLAGS_0,
  output logic [7:0] TAP_POS,
  output logic       BUSY,
  output logic       LIMIT_ERR
);

  localparam int VW = $clog2(SAMPLE_WIN + 1);
  localparam int NW = VW + 1;
  localparam logic signed [NW-1:0] ONE_S   = NW'(1);
  localparam logic signed [NW-1:0] THR_POS = NW'(THRESH);
  localparam logic signed [NW-1:0] THR_NEG = -THR_POS;
  localparam logic [VW-1:0]        VOTE_LAST = VW'(SAMPLE_WIN - 1);
  localparam logic [7:0]           SETTLE_LD = 8'(SETTLE_CYC - 1);
  localparam logic [7:0]           TAP_INIT_V = 8'(TAP_INIT);
  localparam logic [7:0]           TAP_MAX_V  = 8'(TAP_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_SAMPLE, S_DECIDE, S_MOVE, S_SETTLE
  } state_t;

  state_t                 state_q, state_d;
  logic signed [NW-1:0]   net_q, net_d;
  logic [VW-1:0]          votes_q, votes_d;
  logic [7:0]             tap_q, tap_d;
  logic [7:0]             settle_q, settle_d;
  logic                   dir_q, dir_d;
  logic                   lim_q, lim_d;
  logic                   undo_q, undo_d;
  logic                   up_ok, dn_ok, go_move;
`ifdef DDR3_DQS_TRACK_HYST_EN
  logic                   pend_v_q, pend_v_d;
  logic                   pend_dir_q, pend_dir_d;
`endif

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q  <= S_IDLE;
      net_q    <= '0;
      votes_q  <= '0;
      tap_q    <= '0;
      settle_q <= '0;
      dir_q    <= 1'b0;
      lim_q    <= 1'b0;
      undo_q   <= 1'b0;
`ifdef DDR3_DQS_TRACK_HYST_EN
      pend_v_q   <= 1'b0;
      pend_dir_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      net_q    <= net_d;
      votes_q  <= votes_d;
      tap_q    <= tap_d;
      settle_q <= settle_d;
      dir_q    <= dir_d;
      lim_q    <= lim_d;
      undo_q   <= undo_d;
`ifdef DDR3_DQS_TRACK_HYST_EN
      pend_v_q   <= pend_v_d;
      pend_dir_q <= pend_dir_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    net_d    = net_q;
    votes_d  = votes_q;
    tap_d    = tap_q;
    settle_d = settle_q;
    dir_d    = dir_q;
    lim_d    = lim_q;
    undo_d   = undo_q;
    up_ok    = (net_q >= THR_POS) && (tap_q < TAP_MAX_V);
    dn_ok    = (net_q <= THR_NEG) && (tap_q != 8'd0);
    go_move  = 1'b0;
`ifdef DDR3_DQS_TRACK_HYST_EN
    pend_v_d   = pend_v_q;
    pend_dir_d = pend_dir_q;
`endif
    case (state_q)
      S_IDLE: if (TRACK_EN) state_d = S_CLEAR;
      S_LOAD: begin
        tap_d    = TAP_INIT_V;
        lim_d    = 1'b0;
        net_d    = '0;
        votes_d  = '0;
        undo_d   = 1'b0;
        settle_d = SETTLE_LD;
        state_d  = S_SETTLE;
`ifdef DDR3_DQS_TRACK_HYST_EN
        pend_v_d = 1'b0;
`endif
      end
      S_CLEAR: begin
        if (TRACK_EN) state_d = S_SAMPLE;
        else begin
          state_d = S_IDLE;
          net_d   = '0;
          votes_d = '0;
        end
      end
      S_SAMPLE: begin
        if (!TRACK_EN) begin
          state_d = S_IDLE;
          net_d   = '0;
          votes_d = '0;
        end else if (RD_VALID) begin
          if (EYE_MONITOR_EARLY_0 && !EYE_MONITOR_LATE_0) net_d = net_q + ONE_S;
          else if (EYE_MONITOR_LATE_0 && !EYE_MONITOR_EARLY_0) net_d = net_q - ONE_S;
          votes_d = votes_q + VW'(1);
          state_d = (votes_q == VOTE_LAST) ? S_DECIDE : S_CLEAR;
        end
      end
      S_DECIDE: begin
        net_d   = '0;
        votes_d = '0;
`ifdef DDR3_DQS_TRACK_HYST_EN
        // A move needs a matching pending direction; anything else re-arms or drops it.
        if ((up_ok || dn_ok) && pend_v_q && (pend_dir_q == up_ok)) begin
          go_move  = 1'b1;
          pend_v_d = 1'b0;
        end else if ((up_ok || dn_ok) && !pend_v_q) begin
          pend_v_d   = 1'b1;
          pend_dir_d = up_ok;
        end else begin
          pend_v_d = 1'b0;
        end
`else
        go_move = up_ok || dn_ok;
`endif
        if (!TRACK_EN) state_d = S_IDLE;
        else if (go_move) begin
          dir_d   = up_ok;
          state_d = S_MOVE;
        end else state_d = S_CLEAR;
      end
      S_MOVE: begin
        tap_d    = dir_q ? tap_q + 8'd1 : tap_q - 8'd1;
        undo_d   = 1'b1;
        settle_d = SETTLE_LD;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        // Out-of-range reverts only the move that led here, once.
        if (DELAY_LINE_OUT_OF_RANGE_0) begin
          lim_d = 1'b1;
          if (undo_q) begin
            tap_d  = dir_q ? tap_q - 8'd1 : tap_q + 8'd1;
            undo_d = 1'b0;
          end
        end
        if (settle_q == 8'd0) begin
          undo_d  = 1'b0;
          state_d = TRACK_EN ? S_CLEAR : S_IDLE;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (LOAD_REQ) begin
      state_d = S_LOAD;
      net_d   = '0;
      votes_d = '0;
    end
  end

  always_comb begin
    DELAY_LINE_MOVE_0         = (state_q == S_MOVE);
    DELAY_LINE_LOAD_0         = (state_q == S_LOAD);
    EYE_MONITOR_CLEAR_FLAGS_0 = (state_q == S_CLEAR);
    BUSY                      = (state_q != S_IDLE);
    DELAY_LINE_DIRECTION_0    = dir_q;
    TAP_POS                   = tap_q;
    LIMIT_ERR                 = lim_q;
  end

endmodule

// File: tb/tb_ddr3_dqs_delay_tracker.sv
// Directed bench for ddr3_dqs_delay_tracker; expected moves are queued and matched on each MOVE strobe.
module tb_ddr3_dqs_delay_tracker;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N = 1'b0;
  logic       TRACK_EN = 1'b0, LOAD_REQ = 1'b0, RD_VALID = 1'b0;
  logic       EARLY = 1'b0, LATE = 1'b0, OOR = 1'b0;
  logic       MOVE, DIR, LOAD, CLEAR, BUSY, LIMIT_ERR;
  logic [7:0] TAP_POS;

  ddr3_dqs_delay_tracker dut (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .TRACK_EN(TRACK_EN), .LOAD_REQ(LOAD_REQ),
    .RD_VALID(RD_VALID), .EYE_MONITOR_EARLY_0(EARLY), .EYE_MONITOR_LATE_0(LATE),
    .DELAY_LINE_OUT_OF_RANGE_0(OOR), .DELAY_LINE_MOVE_0(MOVE),
    .DELAY_LINE_DIRECTION_0(DIR), .DELAY_LINE_LOAD_0(LOAD),
    .EYE_MONITOR_CLEAR_FLAGS_0(CLEAR), .TAP_POS(TAP_POS), .BUSY(BUSY),
    .LIMIT_ERR(LIMIT_ERR)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    logic       dir;
    logic [7:0] tap;
  } mv_t;

  mv_t sb[$];
  int  checks = 0, errors = 0, moves = 0;
  int  exp_tap = 0;
  int  exp_lim = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge FAB_CLK) begin
    if (MOVE === 1'b1) begin
      mv_t e;
      moves++;
      chk("move_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("move_dir", 32'(DIR), 32'(e.dir));
        chk("move_tap_before", 32'(TAP_POS), 32'(e.tap));
      end
    end
  end

  task automatic tick();
    @(posedge FAB_CLK);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 100) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(BUSY), 0);
  endtask

  task automatic do_load();
    LOAD_REQ = 1'b1;
    tick();
    chk("load_strobe", 32'(LOAD), 1);
    chk("load_busy", 32'(BUSY), 1);
    LOAD_REQ = 1'b0;
    tick();
    chk("load_strobe_once", 32'(LOAD), 0);
    exp_tap = 1;
    exp_lim = 0;
    chk("load_tap", 32'(TAP_POS), 32'(exp_tap));
    chk("load_limit", 32'(LIMIT_ERR), 32'(exp_lim));
    begin
      int n = 0;
      while (BUSY && n < 50) begin
        tick();
        n++;
      end
      chk("settle_cycles", n, 8);
    end
  endtask

  // mode 0: EARLY, 1: LATE, 2: alternating EARLY/LATE per capture
  task automatic run_window(input int mode, input bit exp_mv, input bit oor);
    int nclr = 0, c = 0, c16 = -1000, cev = 0, m0;
    bit mv = 0, done = 0;
    m0 = moves;
    if (exp_mv) sb.push_back('{(mode == 0), 8'(exp_tap)});
    TRACK_EN = 1'b1;
    RD_VALID = 1'b1;
    EARLY = (mode == 0);
    LATE  = (mode == 1);
    while (!done && c < 200) begin
      tick();
      c++;
      if (CLEAR) begin
        nclr++;
        if (nclr == 16) c16 = c;
        if (mode == 2) begin
          EARLY = (nclr % 2 == 1);
          LATE  = (nclr % 2 == 0);
        end
        if (nclr == 17) begin
          cev = c;
          done = 1;
          TRACK_EN = 1'b0;
        end
      end
      if (MOVE) begin
        mv = 1;
        cev = c;
        done = 1;
        TRACK_EN = 1'b0;
        RD_VALID = 1'b0;
        OOR = oor;
      end
    end
    RD_VALID = 1'b0;
    EARLY = 1'b0;
    LATE = 1'b0;
    TRACK_EN = 1'b0;
    wait_idle();
    OOR = 1'b0;
    chk("window_moved", 32'(mv), 32'(exp_mv));
    chk("move_count", moves - m0, 32'(exp_mv));
    chk("decide_latency", cev - c16, 3);
    if (exp_mv) chk("clears_per_window", nclr, 16);
    if (exp_mv && !oor) exp_tap += (mode == 0) ? 1 : -1;
    if (exp_mv && oor) exp_lim = 1;
    chk("tap_pos", 32'(TAP_POS), 32'(exp_tap));
    chk("limit_err", 32'(LIMIT_ERR), 32'(exp_lim));
  endtask

  initial begin
    #12;
    chk("rst_move", 32'(MOVE), 0);
    chk("rst_dir", 32'(DIR), 0);
    chk("rst_load", 32'(LOAD), 0);
    chk("rst_clear", 32'(CLEAR), 0);
    chk("rst_tap", 32'(TAP_POS), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_limit", 32'(LIMIT_ERR), 0);
    ARST_N = 1'b1;
    tick();

    do_load();
    run_window(0, 1, 0);
    run_window(2, 0, 0);
    run_window(1, 1, 0);
    run_window(1, 1, 0);
    run_window(1, 0, 0);

    do_load();
    for (int i = 0; i < 4; i++) run_window(0, 1, 0);
    run_window(0, 1, 1);
    run_window(2, 0, 0);
    do_load();

    for (int i = 0; i < 126; i++) run_window(0, 1, 0);
    run_window(0, 0, 0);

    // Abort a window in SAMPLE with nine votes already taken.
    do_load();
    begin
      int nclr = 0, c = 0;
      TRACK_EN = 1'b1;
      RD_VALID = 1'b1;
      EARLY = 1'b1;
      while (nclr < 10 && c < 100) begin
        tick();
        c++;
        if (CLEAR) nclr++;
      end
      chk("abort_reached_vote9", nclr, 10);
      tick();
      TRACK_EN = 1'b0;
      RD_VALID = 1'b0;
      EARLY = 1'b0;
      do_load();
    end
    run_window(0, 1, 0);

    begin
      int c = 0;
      TRACK_EN = 1'b1;
      RD_VALID = 1'b1;
      EARLY = 1'b1;
      while (!MOVE && c < 200) begin
        tick();
        c++;
      end
      chk("move_before_reset", 32'(MOVE), 1);
      ARST_N = 1'b0;
      #1;
      chk("arst_move", 32'(MOVE), 0);
      chk("arst_dir", 32'(DIR), 0);
      chk("arst_load", 32'(LOAD), 0);
      chk("arst_clear", 32'(CLEAR), 0);
      chk("arst_tap", 32'(TAP_POS), 0);
      chk("arst_busy", 32'(BUSY), 0);
      chk("arst_limit", 32'(LIMIT_ERR), 0);
      TRACK_EN = 1'b0;
      RD_VALID = 1'b0;
      EARLY = 1'b0;
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
